// File: rtl/h3_scrub_pkg.sv
// Shared types for the h3 memory scrubber.
package h3_scrub_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_WRITE = 3'd4,
    S_NEXT  = 3'd5,
    S_DONE  = 3'd6
  } scrub_state_t;

endpackage

// File: rtl/h3_correct_n_k.sv
// Combinational single-error corrector for a Hamming (n, k) word laid out with
// parity bits at the power-of-two positions (bit i holds position i+1).
module h3_correct_n_k #(
  parameter int n = 15,
  parameter int k = 11
) (
  input  logic [n-1:0] word_i,
  output logic [n-1:0] corrected_o,
  output logic         sec_o
);

  localparam int SW = n - k;

  // Syndrome is the XOR of the positions of all set bits; zero for a codeword.
  function automatic logic [SW-1:0] calc_syndrome(input logic [n-1:0] w);
    logic [SW-1:0] s;
    s = '0;
    for (int i = 0; i < n; i++) begin
      if (w[i]) begin
        s = s ^ SW'(i + 1);
      end else begin
        s = s;
      end
    end
    return s;
  endfunction

  logic [SW-1:0] syn_s;
  logic [n-1:0]  flip_s;

  // Non-zero syndrome names the single position to invert.
  always_comb begin
    syn_s  = calc_syndrome(word_i);
    flip_s = '0;
    for (int i = 0; i < n; i++) begin
      flip_s[i] = (syn_s == SW'(i + 1));
    end
    corrected_o = word_i ^ flip_s;
    sec_o       = (syn_s != '0);
  end

endmodule

// File: rtl/h3_scrub_n_k.sv
// Background scrubber: reads every RAM word, corrects single-bit errors and
// writes corrected words back, keeping a saturating correction count.
module h3_scrub_n_k
  import h3_scrub_pkg::*;
#(
  parameter int n     = 15,
  parameter int k     = 11,
  parameter int DEPTH = 256,
  parameter int CNT_W = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             pause_i,
  input  logic             clear_cnt_i,
  output logic [AW-1:0]    ram_addr_o,
  output logic             ram_rd_en_o,
  input  logic [n-1:0]     ram_rd_data_i,
  output logic             ram_wr_en_o,
  output logic [n-1:0]     ram_wr_data_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] sec_count_o,
  output logic [AW-1:0]    last_err_addr_o
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  scrub_state_t     state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [n-1:0]     word_q, word_d;
  logic [n-1:0]     wr_data_q, wr_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    last_q, last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             rd_en_s, wr_en_s;
  logic [n-1:0]     corr_s;
  logic             sec_s;

  h3_correct_n_k #(
    .n (n),
    .k (k)
  ) u_correct (
    .word_i      (word_q),
    .corrected_o (corr_s),
    .sec_o       (sec_s)
  );

  // Pass sequencing, address stepping and RAM strobe decode.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rd_en_s = 1'b0;
    wr_en_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          addr_d  = '0;
          state_d = S_READ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        rd_en_s = !pause_i;
        if (pause_i) state_d = S_READ;
        else         state_d = S_WAIT;
      end
      S_WAIT:  state_d = S_CHECK;
      S_CHECK: begin
        if (sec_s) state_d = S_WRITE;
        else       state_d = S_NEXT;
      end
      S_WRITE: begin
        wr_en_s = !pause_i;
        if (pause_i) state_d = S_WRITE;
        else         state_d = S_NEXT;
      end
      S_NEXT: begin
        if (addr_q == LAST_ADDR) begin
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + AW'(1'b1);
          state_d = S_READ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        addr_d  = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // Datapath next-state: captured word, corrected word, statistics.
  always_comb begin
    if (state_q == S_WAIT) word_d = ram_rd_data_i;
    else                   word_d = word_q;

    if (state_q == S_CHECK) wr_data_d = corr_s;
    else                    wr_data_d = wr_data_q;

    // A clear in the same cycle as a correction leaves the counter at zero.
    if (clear_cnt_i) begin
      cnt_d = '0;
    end else if (wr_en_s && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end

    if (wr_en_s) last_d = addr_q;
    else         last_d = last_q;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      word_q    <= '0;
      wr_data_q <= '0;
      cnt_q     <= '0;
      last_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      word_q    <= word_d;
      wr_data_q <= wr_data_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign ram_addr_o      = addr_q;
  assign ram_rd_en_o     = rd_en_s;
  assign ram_wr_en_o     = wr_en_s;
  assign ram_wr_data_o   = wr_data_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign sec_count_o     = cnt_q;
  assign last_err_addr_o = last_q;

endmodule

// File: doc/h3_scrub_n_k.md
# h3_scrub_n_k

Background memory scrubber for Hamming-protected (n, k) SEC storage. On request, it walks every word of a single-port RAM holding encoded vectors and runs each word through the team's combinational SEC corrector, `h3_correct_n_k`. Any word flagged as corrected is written back. Corrections are counted and the last corrected address is reported. It sits between the configuration/register RAMs and the slow-control block that triggers scrubs and reads statistics.

## Interface
Parameters:
- `n`, 15: encoded word width; legal values are 7 and 15.
- `k`, 11: information bits; 4 pairs with n=7, 11 pairs with n=15.
- `DEPTH`, 256: number of RAM words; minimum 2.
- `CNT_W`, 16: width of the correction counter.
- `AW`, $clog2(DEPTH): address width, derived.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset; synchronous, active-high.
- `start_i` in 1: pulse that starts one full pass; ignored while `busy_o`=1.
- `pause_i` in 1: functional access owns the RAM; the scrubber holds its strobes.
- `clear_cnt_i` in 1: clears `sec_count_o`.
- `ram_addr_o` out AW: RAM address.
- `ram_rd_en_o` out 1: read strobe.
- `ram_rd_data_i` in n: read data, valid exactly 1 cycle after `ram_rd_en_o`.
- `ram_wr_en_o` out 1: write strobe.
- `ram_wr_data_o` out n: corrected word.
- `busy_o` out 1: a pass is in progress.
- `done_o` out 1: one-cycle pulse at the end of a pass.
- `sec_count_o` out CNT_W: saturating count of corrected words.
- `last_err_addr_o` out AW: address of the most recent correction.

## Operation
States are IDLE, READ, WAIT, CHECK, WRITE, NEXT, DONE.
- **IDLE:** `start_i`=1 sets the address to 0, and the FSM moves to READ.
- **READ:** `ram_rd_en_o` = !`pause_i`. If `pause_i`=1, the FSM stays in READ. Otherwise it moves to WAIT.
- **WAIT:** `ram_rd_data_i` is captured into `word_q`. The FSM moves to CHECK.
- **CHECK:** `word_q` drives the corrector, and its corrected output is registered into `ram_wr_data_o`.
  - If sec=1, the FSM moves to WRITE.
  - If sec=0, the FSM moves to NEXT.
- **WRITE:** `ram_wr_en_o` = !`pause_i`. If `pause_i`=1, the FSM stays in WRITE.
  - When the write strobe is issued, `sec_count_o` increments (saturating at all-ones) and `last_err_addr_o` takes the current address.
  - The FSM then moves to NEXT.
- **NEXT:** if the address is DEPTH-1, the FSM moves to DONE. Otherwise the address increments and the FSM moves to READ.
- **DONE:** `done_o`=1 for this cycle only. The FSM moves to IDLE.

Further rules:
- `busy_o` = (state != IDLE).
- `pause_i` only gates strobes issued in READ and WRITE. A read already issued completes normally through WAIT.
- Data that changed in RAM during a pause is not re-read. The code is SEC only, so a 2-bit error is silently miscorrected and written back. This is accepted behaviour and does not count as a detection.
- `clear_cnt_i` and an increment in the same cycle: clear wins, and the counter becomes 0.
- `start_i` while busy is dropped, not queued.
- The address never exceeds DEPTH-1. There is no wrap-around; the FSM goes through DONE instead.

## Timing
- Reset values: state IDLE, all strobes 0, `ram_addr_o` 0, `ram_wr_data_o` 0, `busy_o` 0, `done_o` 0, `sec_count_o` 0, `last_err_addr_o` 0.
- `rst` asserted mid-pass aborts the pass immediately. No `done_o` is produced, and the counter is lost.
- Per-word cost without pause: 4 cycles for a clean word, 5 cycles for a corrected word.
- Full pass: `start_i` at cycle 0. `busy_o` is high from cycle 1, and `done_o` occurs at cycle 4·DEPTH + E + 1, where E is the number of corrected words. `busy_o` falls on the following cycle.
- All outputs are registered, except `ram_rd_en_o` and `ram_wr_en_o`, which are decoded from state and `pause_i`.

## Structure
- Package `h3_scrub_pkg` holds the state enum typedef `scrub_state_t`.
- Exactly one sub-module: `h3_correct_n_k`, instantiated with n/k, driven by `word_q`. Its outputs are consumed only in CHECK.
- No other hierarchy. The RAM is external.

## Test plan
- **Clean pass:** n=15, DEPTH=4, all words valid codewords; pulse `start_i`.
  - Expect 4 reads and no writes.
  - Expect `done_o` at cycle 17 and `sec_count_o`=0.
- **Single flip:** word 2 = valid codeword with bit 5 inverted.
  - Expect exactly one write at address 2 carrying the original codeword.
  - Expect `sec_count_o`=1, `last_err_addr_o`=2, and `done_o` at cycle 18.
- **Pause:** `pause_i` held high for 3 cycles while in READ of word 1, then for 2 cycles while in WRITE.
  - Expect no strobes while paused.
  - Expect the pass to complete, with `done_o` delayed by 5 cycles.
- **Counter saturation and clear:** CNT_W=2, 5 corrupted words.
  - Expect `sec_count_o` to saturate at 3.
  - Then assert `clear_cnt_i` coincident with a correction; expect 0.
- **Start while busy and mid-pass reset:** a second `start_i` mid-pass has no effect. Assert `rst` in WAIT of word 2.
  - Expect all outputs at reset values on the next cycle.
  - Expect no `done_o`.
  - A subsequent start restarts from address 0.
- **n=7:** a single-bit error in each of positions 0–6 of a 7-bit codeword.
  - Each position is corrected and written back.
  - Expect `sec_count_o`=7.
